// File: rtl/axon_terminal_synapse_if.sv
// Spike-in / PSC-out bundle between the axon delay stage, the synapse and the soma.
interface axon_terminal_synapse_if #(
  parameter int WEIGHT_W = 8,
  parameter int PSC_W    = 12,
  parameter int RES_MAX  = 4
);
  localparam int RES_W = $clog2(RES_MAX + 1);

  logic                    spike_in;
  logic [WEIGHT_W-1:0]     weight;
  logic                    excitatory;
  logic signed [PSC_W-1:0] psc_out;
  logic [RES_W-1:0]        resources;
  logic                    accepted;
  logic                    dropped;
  logic                    refractory;

  modport master (
    output spike_in, weight, excitatory,
    input  psc_out, resources, accepted, dropped, refractory
  );

  modport slave (
    input  spike_in, weight, excitatory,
    output psc_out, resources, accepted, dropped, refractory
  );
endinterface

// File: rtl/axon_terminal_synapse.sv
// Axon terminal synapse: weighted, saturating PSC with exponential decay, refractory window
// and a vesicle pool that depletes on each accepted spike and recovers one vesicle per period.
module axon_terminal_synapse #(
  parameter int WEIGHT_W       = 8,
  parameter int PSC_W          = 12,
  parameter int DECAY_SHIFT    = 3,
  parameter int DECAY_PERIOD   = 4,
  parameter int REFRACT        = 2,
  parameter int RES_MAX        = 4,
  parameter int RECOVER_PERIOD = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  axon_terminal_synapse_if.slave  bus
);
  localparam int RES_W = $clog2(RES_MAX + 1);
  localparam int DC_W  = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
  localparam int RC_W  = (RECOVER_PERIOD > 1) ? $clog2(RECOVER_PERIOD) : 1;
  localparam int RF_W  = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;

  localparam logic signed [PSC_W:0] PSC_MAX = {2'b00, {(PSC_W-1){1'b1}}};
  localparam logic signed [PSC_W:0] PSC_MIN = {2'b11, {(PSC_W-1){1'b0}}};

  typedef enum logic {ST_READY, ST_REFRACT} state_t;

  state_t                  r_state;
  logic [RF_W-1:0]         r_refr_cnt;
  logic signed [PSC_W-1:0] r_psc;
  logic [RES_W-1:0]        r_res;
  logic [DC_W-1:0]         r_decay_cnt;
  logic [RC_W-1:0]         r_rec_cnt;
  logic                    r_accepted;
  logic                    r_dropped;

  logic                    w_accept;
  logic signed [PSC_W:0]   w_wext;
  logic signed [PSC_W:0]   w_psc_ext;
  logic signed [PSC_W:0]   w_sum;
  logic signed [PSC_W-1:0] w_sat;
  logic signed [PSC_W-1:0] w_shift;
  logic signed [PSC_W-1:0] w_step;
  logic signed [PSC_W-1:0] w_decayed;
  logic                    w_decay_tick;
  logic                    w_rec_tick;

  assign w_accept = bus.spike_in && (r_state == ST_READY) && (r_res != '0);

  // Sum at one extra bit so the clamp sees the true overflow direction.
  assign w_wext    = $signed({{(PSC_W+1-WEIGHT_W){1'b0}}, bus.weight});
  assign w_psc_ext = {r_psc[PSC_W-1], r_psc};
  assign w_sum     = bus.excitatory ? (w_psc_ext + w_wext) : (w_psc_ext - w_wext);
  assign w_sat     = (w_sum > PSC_MAX) ? PSC_MAX[PSC_W-1:0] :
                     (w_sum < PSC_MIN) ? PSC_MIN[PSC_W-1:0] : w_sum[PSC_W-1:0];

  // Positive values get a minimum step of 1 so they reach zero; negatives already do via -1>>>k.
  assign w_shift   = r_psc >>> DECAY_SHIFT;
  assign w_step    = ((w_shift == '0) && !r_psc[PSC_W-1] && (r_psc != '0)) ?
                     {{(PSC_W-1){1'b0}}, 1'b1} : w_shift;
  assign w_decayed = r_psc - w_step;

  assign w_decay_tick = (r_decay_cnt == DC_W'(DECAY_PERIOD - 1));
  assign w_rec_tick   = (r_rec_cnt == RC_W'(RECOVER_PERIOD - 1)) && (r_res != RES_W'(RES_MAX));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_READY;
      r_refr_cnt  <= '0;
      r_psc       <= '0;
      r_res       <= RES_W'(RES_MAX);
      r_decay_cnt <= '0;
      r_rec_cnt   <= '0;
      r_accepted  <= 1'b0;
      r_dropped   <= 1'b0;
    end else begin
      r_accepted <= w_accept;
      r_dropped  <= bus.spike_in && !w_accept;

      if (w_accept) begin
        r_psc       <= w_sat;
        r_decay_cnt <= '0;
      end else if (r_psc != '0) begin
        if (w_decay_tick) begin
          r_psc       <= w_decayed;
          r_decay_cnt <= '0;
        end else begin
          r_decay_cnt <= r_decay_cnt + 1'b1;
        end
      end else begin
        r_decay_cnt <= '0;
      end

      if (r_res != RES_W'(RES_MAX)) begin
        r_rec_cnt <= w_rec_tick ? '0 : (r_rec_cnt + 1'b1);
      end else begin
        r_rec_cnt <= '0;
      end

      // A recovery tick coinciding with an accept cancels out.
      case ({w_accept, w_rec_tick})
        2'b10:   r_res <= r_res - 1'b1;
        2'b01:   r_res <= r_res + 1'b1;
        default: r_res <= r_res;
      endcase

      case (r_state)
        ST_READY: begin
          if (w_accept && (REFRACT > 0)) begin
            r_state    <= ST_REFRACT;
            r_refr_cnt <= RF_W'(REFRACT);
          end
        end
        ST_REFRACT: begin
          r_refr_cnt <= r_refr_cnt - 1'b1;
          if (r_refr_cnt <= RF_W'(1)) begin
            r_state <= ST_READY;
          end
        end
        default: r_state <= ST_READY;
      endcase
    end
  end

  assign bus.psc_out    = r_psc;
  assign bus.resources  = r_res;
  assign bus.accepted   = r_accepted;
  assign bus.dropped    = r_dropped;
  assign bus.refractory = (r_state == ST_REFRACT);
endmodule
